// File: rtl/mh_accept_unit_pkg.sv
// Shared widths, LFSR seed and FSM state encoding for the Metropolis-Hastings accept stage.
package mh_accept_unit_pkg;

    localparam int          DEF_RAND_BITS = 16;
    localparam int          DEF_PROB_BITS = 16;
    localparam int          DEF_DE_BITS   = 8;
    localparam logic [15:0] DEF_SEED      = 16'hACE1;

    typedef enum logic [1:0] {
        ST_SEED   = 2'd0,
        ST_IDLE   = 2'd1,
        ST_LOOKUP = 2'd2,
        ST_HOLD   = 2'd3
    } state_t;

endpackage

// File: rtl/mh_prob_lut.sv
// Acceptance-probability table: one write port, synchronous read-first read port.
module mh_prob_lut #(
    parameter int ADDR_BITS = 7,
    parameter int DATA_BITS = 16
) (
    input  logic                 i_Clk,
    input  logic                 i_Wr,
    input  logic [ADDR_BITS-1:0] i_Wr_Addr,
    input  logic [DATA_BITS-1:0] i_Wr_Data,
    input  logic                 i_Rd,
    input  logic [ADDR_BITS-1:0] i_Rd_Addr,
    output logic [DATA_BITS-1:0] o_Rd_Data
);

    logic [DATA_BITS-1:0] r_Mem [0:(2**ADDR_BITS)-1];
    logic [DATA_BITS-1:0] r_Rd_Data;

    // Same-cycle write and read of one address returns the old word.
    always_ff @(posedge i_Clk) begin
        if (i_Wr) begin
            r_Mem[i_Wr_Addr] <= i_Wr_Data;
        end
        if (i_Rd) begin
            r_Rd_Data <= r_Mem[i_Rd_Addr];
        end
    end

    assign o_Rd_Data = r_Rd_Data;

endmodule

// File: rtl/mh_accept_unit.sv
// Metropolis-Hastings accept/reject stage; seeds and steps the external LFSR.
// Optional ACCEPT_STATS_EN adds saturating accept/total decision counters.
module mh_accept_unit
    import mh_accept_unit_pkg::*;
#(
    parameter int                   RAND_BITS = DEF_RAND_BITS,
    parameter int                   PROB_BITS = DEF_PROB_BITS,
    parameter int                   DE_BITS   = DEF_DE_BITS,
    parameter logic [RAND_BITS-1:0] SEED      = DEF_SEED
) (
    input  logic                 i_Clk,
    input  logic                 i_Rst_L,
    input  logic                 i_DE_DV,
    input  logic [DE_BITS-1:0]   i_DE,
    output logic                 o_DE_Ready,
    input  logic                 i_Lut_Wr,
    input  logic [DE_BITS-2:0]   i_Lut_Addr,
    input  logic [PROB_BITS-1:0] i_Lut_Data,
    output logic                 o_LFSR_Enable,
    output logic                 o_Seed_DV,
    output logic [RAND_BITS-1:0] o_Seed_Data,
    input  logic [RAND_BITS-1:0] i_LFSR_Data,
    output logic                 o_Accept_DV,
    output logic                 o_Accept,
`ifdef ACCEPT_STATS_EN
    output logic [31:0]          o_Accept_Cnt,
    output logic [31:0]          o_Total_Cnt,
`endif
    input  logic                 i_Accept_Ready,
    output logic [1:0]           o_Dbg_State
);

    // Handshakes: a dE transfers on a cycle with i_DE_DV && o_DE_Ready; a decision
    // transfers on a cycle with o_Accept_DV && i_Accept_Ready. Both are sampled at posedge.

    state_t               r_State;
    state_t               w_Next_State;
    logic                 r_Armed;
    logic                 r_De_Nonpos;
    logic                 r_Accept;
    logic                 w_De_Hs;
    logic                 w_Dec_Hs;
    logic [PROB_BITS-1:0] w_Prob;
    logic [PROB_BITS-1:0] w_Rand_Hi;

    assign w_De_Hs   = (r_State == ST_IDLE) && i_DE_DV;
    assign w_Dec_Hs  = (r_State == ST_HOLD) && i_Accept_Ready;
    assign w_Rand_Hi = i_LFSR_Data[RAND_BITS-1 -: PROB_BITS];

    mh_prob_lut #(
        .ADDR_BITS (DE_BITS - 1),
        .DATA_BITS (PROB_BITS)
    ) u_lut (
        .i_Clk     (i_Clk),
        .i_Wr      (i_Lut_Wr),
        .i_Wr_Addr (i_Lut_Addr),
        .i_Wr_Data (i_Lut_Data),
        .i_Rd      (w_De_Hs),
        .i_Rd_Addr (i_DE[DE_BITS-2:0]),
        .o_Rd_Data (w_Prob)
    );

    // r_Armed holds SEED for the first cycle after reset so the seed pulse never overlaps reset.
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            r_State     <= ST_SEED;
            r_Armed     <= 1'b0;
            r_De_Nonpos <= 1'b0;
            r_Accept    <= 1'b0;
        end else begin
            r_State <= w_Next_State;
            r_Armed <= 1'b1;
            if (w_De_Hs) begin
                r_De_Nonpos <= i_DE[DE_BITS-1] | ~(|i_DE);
            end
            if (r_State == ST_LOOKUP) begin
                r_Accept <= r_De_Nonpos | (w_Rand_Hi < w_Prob);
            end
        end
    end

    always_comb begin
        w_Next_State = r_State;
        case (r_State)
            ST_SEED:   if (r_Armed) w_Next_State = ST_IDLE;
            ST_IDLE:   if (i_DE_DV) w_Next_State = ST_LOOKUP;
            ST_LOOKUP: w_Next_State = ST_HOLD;
            ST_HOLD:   if (i_Accept_Ready) w_Next_State = ST_IDLE;
            default:   w_Next_State = ST_SEED;
        endcase
    end

    always_comb begin
        o_DE_Ready    = 1'b0;
        o_LFSR_Enable = 1'b0;
        o_Seed_DV     = 1'b0;
        o_Accept_DV   = 1'b0;
        case (r_State)
            ST_SEED: begin
                o_LFSR_Enable = r_Armed;
                o_Seed_DV     = r_Armed;
            end
            ST_IDLE:   o_DE_Ready    = 1'b1;
            ST_LOOKUP: o_LFSR_Enable = 1'b1;
            ST_HOLD:   o_Accept_DV   = 1'b1;
            default: ;
        endcase
    end

    assign o_Seed_Data = SEED;
    assign o_Accept    = r_Accept;
    assign o_Dbg_State = r_State;

`ifdef ACCEPT_STATS_EN
    logic [31:0] r_Accept_Cnt;
    logic [31:0] r_Total_Cnt;

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            r_Accept_Cnt <= '0;
            r_Total_Cnt  <= '0;
        end else if (w_Dec_Hs) begin
            if (r_Total_Cnt != '1) begin
                r_Total_Cnt <= r_Total_Cnt + 32'd1;
            end
            if (r_Accept && (r_Accept_Cnt != '1)) begin
                r_Accept_Cnt <= r_Accept_Cnt + 32'd1;
            end
        end
    end

    assign o_Accept_Cnt = r_Accept_Cnt;
    assign o_Total_Cnt  = r_Total_Cnt;
`else
    logic w_Unused_Dec_Hs;
    assign w_Unused_Dec_Hs = w_Dec_Hs;
`endif

endmodule
